// File: rtl/inert_burst_intf.sv
// Inertial-sensor SPI front end.
// Brings the sensor up with a fixed configuration sequence, then on every
// data-ready interrupt reads NUM_CH consecutive 16-bit registers (low byte
// first) through an external SPI monarch and publishes them as one coherent
// snapshot together with a single-cycle vld pulse.
//
// SPI handshake: spi_wrt is a one-clock request carrying spi_cmd. Exactly one
// transaction may be outstanding; the next spi_wrt is only raised on the same
// edge that samples the spi_done pulse closing the previous one, and spi_cmd
// is forced to zero on every cycle without spi_wrt. spi_rd_data[7:0] is taken
// on the spi_done cycle; the upper byte is ignored.
//
// state_dbg_o encoding: 0 STARTUP, 1 CFG1, 2 CFG2, 3 CFG_WAIT, 4 WAIT_INT,
// 5 RD_L, 6 RD_H, 7 PUBLISH.
module inert_burst_intf #(
  parameter int         NUM_CH       = 3,
  parameter logic [6:0] BASE_ADDR    = 7'h22,
  parameter int         STARTUP_BITS = 16,
  parameter int         TO_BITS      = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   INT,
  input  logic                   spi_done,
  input  logic [15:0]            spi_rd_data,
  output logic                   spi_wrt,
  output logic [15:0]            spi_cmd,
  output logic [16*NUM_CH-1:0]   samples,
  output logic                   vld,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   int_timeout,
  output logic [2:0]             state_dbg_o
);

  typedef enum logic [2:0] {
    ST_STARTUP  = 3'd0,
    ST_CFG1     = 3'd1,
    ST_CFG2     = 3'd2,
    ST_CFG_WAIT = 3'd3,
    ST_WAIT_INT = 3'd4,
    ST_RD_L     = 3'd5,
    ST_RD_H     = 3'd6,
    ST_PUBLISH  = 3'd7
  } state_t;

  localparam logic [15:0] CMD_CFG0 = 16'h0D02;
  localparam logic [15:0] CMD_CFG1 = 16'h1160;
  localparam logic [15:0] CMD_CFG2 = 16'h1440;

  localparam logic [STARTUP_BITS-1:0] SU_ONES = {STARTUP_BITS{1'b1}};
  localparam logic [STARTUP_BITS-1:0] SU_LAST = SU_ONES - STARTUP_BITS'(1);
  localparam logic [TO_BITS-1:0]      TO_ONES = {TO_BITS{1'b1}};
  localparam logic [2:0]              LAST_CH = 3'(NUM_CH - 1);

  state_t                    state_q;
  logic [STARTUP_BITS-1:0]   su_cnt_q;
  logic [TO_BITS-1:0]        to_cnt_q;
  logic [2:0]                ch_q;
  logic                      spi_wrt_q;
  logic [15:0]               spi_cmd_q;
  logic [16*NUM_CH-1:0]      samples_q;
  logic                      vld_q;
  logic                      busy_q;
  logic                      cfg_done_q;
  logic                      int_to_q;
  logic [15:0]               stg_q [NUM_CH];
  logic                      int_meta_q;
  logic                      int_sync_q;

  // Only the low byte of each read carries register data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^spi_rd_data[15:8];

  // Sensor register address for channel ch, low (hi=0) or high (hi=1) byte;
  // wraps modulo 128 like the sensor's own auto-increment.
  function automatic logic [6:0] reg_addr(input logic [2:0] ch, input logic hi);
    return BASE_ADDR + {3'b000, ch, hi};
  endfunction

  // SPI read command: bit 15 set selects a read of the given address.
  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

  // Two-flop synchroniser for the asynchronous data-ready interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
    end
  end

  // Main sequencer: power-up wait, configuration writes, burst reads and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STARTUP;
      su_cnt_q   <= '0;
      to_cnt_q   <= '0;
      ch_q       <= '0;
      spi_wrt_q  <= 1'b0;
      spi_cmd_q  <= '0;
      samples_q  <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      int_to_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) stg_q[k] <= '0;
    end else begin
      // Pulse outputs default low; spi_cmd is zero whenever spi_wrt is low.
      spi_wrt_q <= 1'b0;
      spi_cmd_q <= '0;
      vld_q     <= 1'b0;
      int_to_q  <= 1'b0;
      case (state_q)
        ST_STARTUP: begin
          su_cnt_q <= su_cnt_q + STARTUP_BITS'(1);
          if (su_cnt_q == SU_LAST) begin
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= CMD_CFG0;
            state_q   <= ST_CFG1;
          end
        end
        ST_CFG1: begin
          if (spi_done) begin
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= CMD_CFG1;
            state_q   <= ST_CFG2;
          end
        end
        ST_CFG2: begin
          if (spi_done) begin
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= CMD_CFG2;
            state_q   <= ST_CFG_WAIT;
          end
        end
        ST_CFG_WAIT: begin
          if (spi_done) begin
            cfg_done_q <= 1'b1;
            to_cnt_q   <= '0;
            state_q    <= ST_WAIT_INT;
          end
        end
        ST_WAIT_INT: begin
          ch_q <= '0;
          if (int_sync_q && en) begin
            // Level-sensitive start: INT still high after a burst starts another.
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= rd_cmd(reg_addr(3'd0, 1'b0));
            busy_q    <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= ST_RD_L;
          end else if (int_sync_q || !en) begin
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_BITS'(1);
            if (to_cnt_q == TO_ONES) begin
              // Sensor went silent: redo configuration, skipping the power-up wait.
              int_to_q   <= 1'b1;
              cfg_done_q <= 1'b0;
              spi_wrt_q  <= 1'b1;
              spi_cmd_q  <= CMD_CFG0;
              state_q    <= ST_CFG1;
            end
          end
        end
        ST_RD_L: begin
          if (spi_done) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_q == 3'(k)) stg_q[k][7:0] <= spi_rd_data[7:0];
            end
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= rd_cmd(reg_addr(ch_q, 1'b1));
            state_q   <= ST_RD_H;
          end
        end
        ST_RD_H: begin
          if (spi_done) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_q == 3'(k)) stg_q[k][15:8] <= spi_rd_data[7:0];
            end
            if (ch_q < LAST_CH) begin
              ch_q      <= ch_q + 3'd1;
              spi_wrt_q <= 1'b1;
              spi_cmd_q <= rd_cmd(reg_addr(ch_q + 3'd1, 1'b0));
              state_q   <= ST_RD_L;
            end else begin
              state_q <= ST_PUBLISH;
            end
          end
        end
        ST_PUBLISH: begin
          // All channels land together so consumers never see a mixed snapshot.
          for (int k = 0; k < NUM_CH; k++) samples_q[16*k +: 16] <= stg_q[k];
          vld_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_WAIT_INT;
        end
        default: state_q <= ST_STARTUP;
      endcase
    end
  end

  assign spi_wrt     = spi_wrt_q;
  assign spi_cmd     = spi_cmd_q;
  assign samples     = samples_q;
  assign vld         = vld_q;
  assign busy        = busy_q;
  assign cfg_done    = cfg_done_q;
  assign int_timeout = int_to_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_inert_burst_intf.sv
// Bench for inert_burst_intf: SPI monarch model with programmable latency,
// command/snapshot scoreboards and scenario tasks run in sequence.
module tb_inert_burst_intf;

  localparam int         NUM_CH       = 3;
  localparam logic [6:0] BASE_ADDR    = 7'h22;
  localparam int         STARTUP_BITS = 6;
  localparam int         TO_BITS      = 8;
  localparam int         SW           = 16 * NUM_CH;
  localparam int         SU_CLKS      = (1 << STARTUP_BITS) - 1;
  localparam int         TO_CLKS      = 1 << TO_BITS;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          int_in = 1'b0;
  logic          spi_done = 1'b0;
  logic [15:0]   spi_rd_data = 16'h0;
  logic          spi_wrt;
  logic [15:0]   spi_cmd;
  logic [SW-1:0] samples;
  logic          vld;
  logic          busy;
  logic          cfg_done;
  logic          int_timeout;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  inert_burst_intf #(
    .NUM_CH(NUM_CH), .BASE_ADDR(BASE_ADDR),
    .STARTUP_BITS(STARTUP_BITS), .TO_BITS(TO_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .INT(int_in),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .samples(samples),
    .vld(vld), .busy(busy), .cfg_done(cfg_done),
    .int_timeout(int_timeout), .state_dbg_o(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int n_wrt = 0;
  int n_to = 0;
  int cyc_cnt = 0;
  int last_done_cyc = 0;
  int spi_lat = 32;
  bit outst = 1'b0;
  logic [SW-1:0] prev_samples = '0;

  logic [15:0]   exp_cmd_q[$];
  logic [SW-1:0] exp_smp_q[$];
  logic [7:0]    rd_byte_q[$];

  // Cycle counter and outstanding-transaction tracker (posedge view).
  initial forever begin
    @(posedge clk);
    cyc_cnt = cyc_cnt + 1;
    if (spi_done === 1'b1) begin
      last_done_cyc = cyc_cnt;
      outst = 1'b0;
    end
    if (rst_n !== 1'b1) outst = 1'b0;
  end

  // SPI monarch model: done pulse spi_lat clocks after each request.
  initial begin : spi_model
    bit aborted;
    forever begin
      if (spi_wrt === 1'b1 && rst_n === 1'b1) begin
        aborted = 1'b0;
        for (int i = 0; i < spi_lat; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          spi_rd_data[15:8] = 8'($urandom_range(0, 255));
          if (rd_byte_q.size() > 0) spi_rd_data[7:0] = rd_byte_q.pop_front();
          else spi_rd_data[7:0] = 8'($urandom_range(0, 255));
          spi_done = 1'b1;
          @(negedge clk);
          spi_done = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Scoreboard: commands and snapshots checked as the DUT produces them.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (spi_wrt === 1'b1) begin
        n_wrt++;
        n_cmp++;
        if (outst) begin
          n_fail++;
          $display("FAIL spi_overlap: spi_wrt=1 with a transaction outstanding, required no overlap");
        end
        outst = 1'b1;
        n_cmp++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL spi_cmd_unexpected: got %h, required no command", spi_cmd);
        end else begin
          logic [15:0] e;
          e = exp_cmd_q.pop_front();
          if (spi_cmd !== e) begin
            n_fail++;
            $display("FAIL spi_cmd: got %h, required %h", spi_cmd, e);
          end
        end
      end else begin
        n_cmp++;
        if (spi_cmd !== 16'h0) begin
          n_fail++;
          $display("FAIL spi_cmd_idle: got %h, required 0000", spi_cmd);
        end
      end
      if (int_timeout === 1'b1) n_to++;
      if (vld === 1'b1) begin
        n_cmp++;
        if (exp_smp_q.size() == 0) begin
          n_fail++;
          $display("FAIL vld_unexpected: samples %h, required no vld", samples);
        end else begin
          logic [SW-1:0] es;
          es = exp_smp_q.pop_front();
          if (samples !== es) begin
            n_fail++;
            $display("FAIL samples: got %h, required %h", samples, es);
          end
        end
      end else begin
        n_cmp++;
        if (samples !== prev_samples) begin
          n_fail++;
          $display("FAIL samples_hold: got %h without vld, required %h", samples, prev_samples);
        end
      end
    end
    prev_samples = samples;
  end

  // Watchdog against a stuck run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Queue one burst: expected read commands plus model data and snapshot.
  task automatic queue_burst(input logic [7:0] b [2*NUM_CH]);
    logic [SW-1:0] s;
    logic [6:0]    a;
    s = '0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      a = BASE_ADDR + 7'(k);
      exp_cmd_q.push_back({1'b1, a, 8'h00});
      rd_byte_q.push_back(b[k]);
    end
    for (int k = 0; k < NUM_CH; k++) s[16*k +: 16] = {b[2*k+1], b[2*k]};
    exp_smp_q.push_back(s);
  endtask

  task automatic random_burst();
    logic [7:0] b [2*NUM_CH];
    for (int k = 0; k < 2 * NUM_CH; k++) b[k] = 8'($urandom_range(0, 255));
    queue_burst(b);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({spi_wrt, spi_cmd, vld, busy, cfg_done, int_timeout} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wrt=%b cmd=%h vld=%b busy=%b cfg=%b to=%b, required all 0",
               spi_wrt, spi_cmd, vld, busy, cfg_done, int_timeout);
    end
    n_cmp++;
    if (samples !== '0) begin
      n_fail++;
      $display("FAIL reset_samples: got %h, required 0", samples);
    end
    n_cmp++;
    if (state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required 0 (STARTUP)", state_dbg);
    end
  endtask

  // Release reset, time the power-up wait and walk the configuration writes.
  task automatic test_startup();
    int cyc;
    bit found;
    spi_lat = 32;
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1160);
    exp_cmd_q.push_back(16'h1440);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 4 * SU_CLKS) begin
      @(negedge clk);
      cyc++;
      if (spi_wrt === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || cyc != SU_CLKS) begin
      n_fail++;
      $display("FAIL startup_wait: first spi_wrt after %0d clocks (seen=%0b), required %0d", cyc, found, SU_CLKS);
    end
    n_cmp++;
    if (cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_done_early: got %b, required 0", cfg_done);
    end
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cfg_done === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL cfg_done_timeout: cfg_done=%b after %0d clocks, required 1", cfg_done, cyc);
    end
    n_cmp++;
    if (cyc_cnt - last_done_cyc != 0) begin
      n_fail++;
      $display("FAIL cfg_done_timing: rose %0d clocks after done, required 0", cyc_cnt - last_done_cyc);
    end
    n_cmp++;
    if (exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL cfg_cmds: %0d commands missing, required 0", exp_cmd_q.size());
    end
  endtask

  task automatic test_burst();
    logic [7:0] b [2*NUM_CH];
    int cyc;
    int w0;
    bit found;
    bit gap;
    spi_lat = 3;
    en = 1'b1;
    for (int k = 0; k < 2 * NUM_CH; k++) b[k] = 8'h11 + 8'(k);
    queue_burst(b);
    n_cmp++;
    if (exp_smp_q[0] !== {16'h1615, 16'h1413, 16'h1211} || exp_cmd_q[5] !== 16'hA700) begin
      n_fail++;
      $display("FAIL burst_table: got %h / %h, required 161514131211 / a700", exp_smp_q[0], exp_cmd_q[5]);
    end
    w0 = n_wrt;
    int_in = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (spi_wrt === 1'b1) found = 1'b1;
    end
    int_in = 1'b0;
    n_cmp++;
    if (!found || cyc != 3) begin
      n_fail++;
      $display("FAIL burst_start: first read after %0d clocks (seen=%0b), required 3", cyc, found);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_busy_start: got %b, required 1", busy);
    end
    cyc = 0;
    found = 1'b0;
    gap = 1'b0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (vld === 1'b1) found = 1'b1;
      else if (busy !== 1'b1) gap = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL burst_vld_timeout: vld=%b after %0d clocks, required 1", vld, cyc);
    end
    n_cmp++;
    if (gap) begin
      n_fail++;
      $display("FAIL burst_busy_gap: busy dropped before vld, required held high");
    end
    n_cmp++;
    if (cyc_cnt - last_done_cyc != 1) begin
      n_fail++;
      $display("FAIL vld_latency: %0d clocks after last done, required 1", cyc_cnt - last_done_cyc);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_busy_end: got %b at vld, required 0", busy);
    end
    n_cmp++;
    if (n_wrt - w0 != 2 * NUM_CH) begin
      n_fail++;
      $display("FAIL burst_count: %0d transactions, required %0d", n_wrt - w0, 2 * NUM_CH);
    end
    @(negedge clk);
    n_cmp++;
    if (vld !== 1'b0 || samples !== {16'h1615, 16'h1413, 16'h1211}) begin
      n_fail++;
      $display("FAIL vld_pulse: vld=%b samples=%h, required vld=0 samples=161514131211", vld, samples);
    end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int nv;
    int cyc;
    int w0;
    spi_lat = 2;
    for (int i = 0; i < 3; i++) random_burst();
    nv = 0;
    cyc = 0;
    int_in = 1'b1;
    while (nv < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (vld === 1'b1) begin
        t[nv] = cyc_cnt;
        nv++;
        if (nv == 2) int_in = 1'b0;
      end
    end
    n_cmp++;
    if (nv != 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d vld pulses, required 3", nv);
    end else begin
      n_cmp++;
      if (t[1] - t[0] != 6 * (spi_lat + 1) + 2 || t[2] - t[1] != 6 * (spi_lat + 1) + 2) begin
        n_fail++;
        $display("FAIL b2b_period: %0d and %0d clocks, required %0d", t[1] - t[0], t[2] - t[1],
                 6 * (spi_lat + 1) + 2);
      end
    end
    w0 = n_wrt;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (n_wrt != w0) begin
      n_fail++;
      $display("FAIL b2b_stop: %0d extra transactions after INT low, required 0", n_wrt - w0);
    end
  endtask

  task automatic test_en_gate();
    int w0;
    int to0;
    int cyc;
    bit found;
    en = 1'b0;
    int_in = 1'b1;
    w0 = n_wrt;
    to0 = n_to;
    repeat (TO_CLKS + 40) @(negedge clk);
    n_cmp++;
    if (n_wrt != w0 || n_to != to0) begin
      n_fail++;
      $display("FAIL en_gate: %0d transactions, %0d timeouts with en=0, required 0 and 0", n_wrt - w0, n_to - to0);
    end
    n_cmp++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL en_gate_cfg: cfg_done=%b, required 1", cfg_done);
    end
    spi_lat = 3;
    random_burst();
    en = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (spi_wrt === 1'b1) found = 1'b1;
    end
    en = 1'b0;
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL en_start: no spi_wrt after en rose, required one");
    end
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (vld === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL en_drop_burst: vld=%b after %0d clocks, required burst to complete", vld, cyc);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (n_wrt - w0 != 2 * NUM_CH) begin
      n_fail++;
      $display("FAIL en_drop_block: %0d transactions, required %0d", n_wrt - w0, 2 * NUM_CH);
    end
    int_in = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc;
    bit found;
    repeat (4) @(negedge clk);
    spi_lat = 4;
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1160);
    exp_cmd_q.push_back(16'h1440);
    en = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < TO_CLKS + 100) begin
      @(negedge clk);
      cyc++;
      if (int_timeout === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || cyc != TO_CLKS) begin
      n_fail++;
      $display("FAIL timeout_time: pulse after %0d clocks (seen=%0b), required %0d", cyc, found, TO_CLKS);
    end
    n_cmp++;
    if (spi_wrt !== 1'b1 || cfg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_action: wrt=%b cfg_done=%b, required wrt=1 cfg_done=0", spi_wrt, cfg_done);
    end
    @(negedge clk);
    n_cmp++;
    if (int_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %b a clock later, required 0", int_timeout);
    end
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cfg_done === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_reconfig: cfg_done=%b, %0d commands missing, required 1 and 0", cfg_done, exp_cmd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    spi_lat = 3;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_cmd_q.push_back({1'b1, BASE_ADDR + 7'(k), 8'h00});
      rd_byte_q.push_back(8'($urandom_range(0, 255)));
    end
    int_in = 1'b1;
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (spi_wrt === 1'b1 && spi_cmd === 16'hA500) found = 1'b1;
    end
    int_in = 1'b0;
    n_cmp++;
    if (!found || state_dbg !== 3'd6) begin
      n_fail++;
      $display("FAIL mid_reach: seen=%0b state=%0d, required RD_H (6)", found, state_dbg);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (samples !== '0 || vld !== 1'b0 || spi_wrt !== 1'b0 || busy !== 1'b0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: samples=%h vld=%b wrt=%b busy=%b state=%0d, required all 0",
               samples, vld, spi_wrt, busy, state_dbg);
    end
    n_cmp++;
    if (exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_cmds: %0d commands missing before reset, required 0", exp_cmd_q.size());
    end
    rd_byte_q.delete();
    int_in = 1'b0;
    repeat (3) @(negedge clk);
    test_startup();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_startup();
    test_burst();
    test_back_to_back();
    test_en_gate();
    test_timeout();
    test_reset_mid();
    n_cmp++;
    if (exp_cmd_q.size() != 0 || exp_smp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queues: %0d commands, %0d snapshots pending, required 0 and 0",
               exp_cmd_q.size(), exp_smp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inert_burst_intf.md
Name: inert_burst_intf

Overview:
Parametrised inertial-sensor SPI front end that reads NUM_CH consecutive 16-bit sensor registers per data-ready interrupt. Example uses are gyro X/Y/Z plus accel. It drives an external SPI monarch through a wrt/done/cmd/rd_data handshake and runs the power-up configuration sequence. It publishes a coherent snapshot of all channels with a one-cycle valid pulse. It adds INT timeout detection with automatic re-configuration, and an enable gate. It sits between the SPI monarch and the heading/integration logic.

Parameters:
NUM_CH, 3, number of 16-bit channels read per burst (1..6)
BASE_ADDR, 7'h22, sensor address of channel 0 low byte; channel k low byte = BASE_ADDR+2k, high byte = BASE_ADDR+2k+1
STARTUP_BITS, 16, power-up wait = 2^STARTUP_BITS-1 clocks
TO_BITS, 20, INT timeout = 2^TO_BITS clocks in WAIT_INT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  allow new bursts to start
INT  in  1  asynchronous sensor data-ready, double-flopped internally
spi_done  in  1  SPI monarch transaction complete (1-clk pulse)
spi_rd_data  in  16  SPI read data; low byte valid on done
spi_wrt  out  1  start SPI transaction (1-clk pulse)
spi_cmd  out  16  SPI command word, valid while spi_wrt high
samples  out  16*NUM_CH  snapshot; channel k at [16k+15:16k], {high byte, low byte}
vld  out  1  1-clk pulse, samples updated this cycle
busy  out  1  high from burst start until vld
cfg_done  out  1  level, high once the configuration sequence has completed
int_timeout  out  1  1-clk pulse on INT timeout

Behaviour:
Reset values:
- All outputs 0, samples all 0.
- State STARTUP; startup timer and timeout counter 0; INT synchronisers 0.

STARTUP:
- Counter increments each clock.
- When all ones, issue spi_wrt with spi_cmd=16'h0D02 and go to CFG1.

CFG1 / CFG2:
- On spi_done, write 16'h1160, then 16'h1440, respectively.
- CFG2 spi_done -> CFG_WAIT.

CFG_WAIT:
- On spi_done, set cfg_done=1 and go to WAIT_INT.

WAIT_INT:
- Channel index ch=0.
- If INT_sync & en: spi_wrt with cmd {1'b1, BASE_ADDR, 8'h00}; busy=1; go to RD_L.
- Otherwise the timeout counter increments; it clears on any INT_sync high.
- Counter wrap (2^TO_BITS clocks with no INT): int_timeout pulse, cfg_done=0, go to CFG1 issuing 16'h0D02. The startup wait is not repeated.
- Counter holds at 0 while en=0.

RD_L:
- On spi_done, latch low byte into staging[ch].
- spi_wrt with cmd {1'b1, BASE_ADDR+2ch+1, 8'h00}; go to RD_H.

RD_H:
- On spi_done, latch high byte into staging[ch].
- If ch<NUM_CH-1: ch++, spi_wrt the next low address, go to RD_L.
- Else go to PUBLISH.

PUBLISH:
- samples<=staging (all channels in one clock); vld=1; busy=0; go to WAIT_INT.

Timing and handshake rules:
- Each burst issues exactly 2*NUM_CH transactions.
- vld occurs one clock after the final spi_done.
- spi_wrt is never asserted while a transaction is outstanding.
- spi_cmd is 0 whenever spi_wrt=0.

Boundary conditions:
- samples are held stable between vld pulses; partial bursts never leak.
- INT still high on return to WAIT_INT starts a new burst on the next clock; no edge is required.
- en dropping mid-burst does not abort the burst; only the next start is blocked.
- Address arithmetic is 7-bit modulo 128.
- Reset mid-burst returns to STARTUP and clears samples.

Test Plan:
- Reset release with no other stimulus -> spi_wrt with 16'h0D02 at exactly 2^STARTUP_BITS-1 clocks. Model done after 32 clocks -> cmds 16'h1160, then 16'h1440, then cfg_done=1.
- INT pulse, NUM_CH=3, model returns 0x11..0x16 -> cmds A200,A300,A400,A500,A600,A700 in order. samples={16'h1615,16'h1413,16'h1211}. vld one clock after 6th done; busy high between start and vld.
- INT held high continuously -> back-to-back bursts. vld pulses separated by 6 transactions + 2 clocks; samples unchanged until each vld.
- en=0 with INT high -> no spi_wrt and no timeout. en asserted mid-burst then deasserted -> current burst completes with vld.
- No INT, TO_BITS=8 -> int_timeout pulse at 256 clocks, cfg_done falls, cmd 16'h0D02 reissued without startup wait.
- Reset asserted during RD_H of channel 1 -> samples=0, vld=0, spi_wrt=0 immediately. Full startup sequence repeats after release.
